// File: rtl/exam1_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// exam1_sweep_ctrl
//   Built-in self-test sequencer for a W-input combinational function block.
//   A start pulse walks vec through 0..2^W-1. Each vector is held for SETTLE
//   cycles, and f_in is captured into the truth-table register tt on the last
//   edge of that window. The captured table is compared bit by bit against
//   the EXPECTED golden table while the sweep runs. A one-cycle done pulse
//   then reports pass, the mismatch count, and the lowest failing vector.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      one-cycle sweep request, accepted only in IDLE
//   abort      in   1      cancels a running sweep; also blocks start in IDLE
//   f_in       in   1      output F of the function block under test
//   vec        out  W      {A,B,C,D} drive to the function block (A = MSB)
//   busy       out  1      sweep in progress
//   done       out  1      one-cycle pulse when the results are valid
//   tt         out  2^W    captured truth table
//   pass       out  1      tt matched EXPECTED (valid from done to next start)
//   mism_cnt   out  W+1    number of mismatching vectors
//   first_fail out  W      lowest mismatching vector
//   fail_vld   out  1      first_fail holds a valid index
// -----------------------------------------------------------------------------
module exam1_sweep_ctrl #(
  parameter int                W        = 4,
  parameter int                SETTLE   = 1,
  parameter logic [(1<<W)-1:0] EXPECTED = 16'h0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                f_in,
  output logic [W-1:0]        vec,
  output logic                busy,
  output logic                done,
  output logic [(1<<W)-1:0]   tt,
  output logic                pass,
  output logic [W:0]          mism_cnt,
  output logic [W-1:0]        first_fail,
  output logic                fail_vld
);

  localparam int N  = 1 << W;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE - 1);
  localparam logic [W-1:0]  VEC_LAST   = W'(N - 1);
  localparam logic [W:0]    MISM_ONE   = (W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // One registered process holds the FSM and every output, so all outputs
  // change only at the clock edge (or at once on reset).
  // NOTE: all state updates use non-blocking assignments. Every register
  // then sees the values from before this edge, which the compare-and-count
  // path depends on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= '0;
      pass       <= 1'b0;
      mism_cnt   <= '0;
      first_fail <= '0;
      fail_vld   <= 1'b0;
    end else begin
      // done is a pulse: it drops on every edge unless FINISH raises it.
      done <= 1'b0;

      unique case (state)
        IDLE: begin
          vec  <= '0;
          busy <= 1'b0;
          // If abort arrives in the same cycle as start, abort wins and
          // no sweep begins.
          if (start && !abort) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= CNT_RELOAD;
            tt       <= '0;
            pass     <= 1'b0;
            mism_cnt <= '0;
            fail_vld <= 1'b0;
          end
        end

        RUN: begin
          if (abort) begin
            // tt and mism_cnt keep their partial values; pass stays low, so
            // the caller knows they are invalid.
            state <= IDLE;
            busy  <= 1'b0;
            vec   <= '0;
            pass  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // This is the last edge of the settle window for this vector.
            tt[vec] <= f_in;
            if (f_in != EXPECTED[vec]) begin
              mism_cnt <= mism_cnt + MISM_ONE;
              if (!fail_vld) begin
                first_fail <= vec;
                fail_vld   <= 1'b1;
              end
            end
            if (vec == VEC_LAST) begin
              // vec is held here, so it never wraps back to 0.
              state <= FINISH;
            end else begin
              vec <= vec + 1'b1;
              cnt <= CNT_RELOAD;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          vec   <= '0;
          if (abort) begin
            pass <= 1'b0;
          end else begin
            // mism_cnt already includes the final sample, which was
            // committed on the previous edge.
            done <= 1'b1;
            pass <= (mism_cnt == '0);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          vec   <= '0;
        end
      endcase
    end
  end

endmodule
